vdc_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one vdcorput_fsm_32bit_simple core among N_REQ requesters, for example the two bases of a disk/sphere generator or several point generators.
- Latches each winning requester's k and base, pulses the core's start, waits for done with a timeout guard, and returns the result to the winner.
- Sits between the point-generator FSMs and a single shared VdC core, so each generator no longer needs its own VdC instance.

---
 rtl/vdc_share_arbiter.sv | 127 ++++++++++++
 tb/tb_vdc_share_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_share_arbiter.sv
// rtl/vdc_share_arbiter.sv - round-robin arbiter sharing one VdC core among N_REQ requesters
module vdc_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*32-1:0]  req_k,
    input  logic [N_REQ*2-1:0]   req_base,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 core_start,
    output logic [31:0]          core_k,
    output logic [1:0]           core_base,
    input  logic [31:0]          core_result,
    input  logic                 core_done,
    input  logic                 core_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  ptr, idx, win, cidx;
    logic [15:0]       cnt;
    logic              found;
    logic [31:0]       sel_k;
    logic [1:0]        sel_base;
    int                cand;

    // Search ptr, ptr+1, ... (mod N_REQ) for the first active request.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand     = 0;
        cidx     = '0;
        sel_k    = '0;
        sel_base = '0;
        for (int j = 0; j < N_REQ; j++) begin
            cand = int'(ptr) + j;
            if (cand >= N_REQ)
                cand = cand - N_REQ;
            cidx = IDX_W'(cand);
            if (!found && req[cidx]) begin
                found = 1'b1;
                win   = cidx;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                sel_k    = req_k[i*32 +: 32];
                sel_base = req_base[i*2 +: 2];
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (found && core_ready) state_n = S_ISSUE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT:  if (core_done || cnt == 16'(TIMEOUT - 1)) state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // All outputs are flops; strobes are loaded from the next-state decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            idx        <= '0;
            cnt        <= '0;
            req_ack    <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            core_start <= 1'b0;
            core_k     <= '0;
            core_base  <= '0;
        end else begin
            state      <= state_n;
            busy       <= (state_n != S_IDLE);
            core_start <= (state_n == S_ISSUE);
            req_ack    <= '0;
            rsp_valid  <= '0;
            case (state)
                S_IDLE: begin
                    if (state_n == S_ISSUE) begin
                        idx       <= win;
                        core_k    <= sel_k;
                        core_base <= sel_base;
                        req_ack   <= N_REQ'(1) << win;
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    // A done arriving on the timeout cycle still delivers its result.
                    if (core_done) begin
                        rsp_data <= core_result;
                        rsp_err  <= 1'b0;
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= N_REQ'(1) << idx;
                    if (idx == IDX_W'(N_REQ - 1))
                        ptr <= '0;
                    else
                        ptr <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vdc_share_arbiter.sv
// tb/tb_vdc_share_arbiter.sv - scoreboard bench for vdc_share_arbiter with a behavioural core
module tb_vdc_share_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] req_k;
    logic [7:0]   req_base;
    logic [3:0]   req_ack;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic         busy;
    logic         core_start;
    logic [31:0]  core_k;
    logic [1:0]   core_base;
    logic [31:0]  core_result;
    logic         core_done;
    logic         core_ready;

    vdc_share_arbiter #(.N_REQ(4), .IDX_W(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_k(req_k), .req_base(req_base),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .core_start(core_start), .core_k(core_k), .core_base(core_base),
        .core_result(core_result), .core_done(core_done), .core_ready(core_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] kv [4];
    logic [1:0]  bv [4];
    logic [31:0] exp_data [4];
    assign req_k    = {kv[3], kv[2], kv[1], kv[0]};
    assign req_base = {bv[3], bv[2], bv[1], bv[0]};

    // Behavioural core: result {k[29:0],base}, done core_lat cycles after start.
    int          core_lat;
    logic        hold_ready;
    logic        running;
    int          ccnt;
    logic [31:0] c_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            ccnt    <= 0;
            c_res   <= '0;
        end else if (core_start && !running) begin
            running <= 1'b1;
            ccnt    <= 1;
            c_res   <= {core_k[29:0], core_base};
        end else if (running) begin
            if (ccnt == core_lat) running <= 1'b0;
            else ccnt <= ccnt + 1;
        end
    end
    assign core_done   = running && (ccnt == core_lat);
    assign core_result = c_res;
    assign core_ready  = !running && !hold_ready;

    typedef struct {int idx; logic [31:0] k; logic [1:0] b;} ack_t;
    typedef struct {int idx; logic [31:0] d; logic e; int lat;} rsp_t;
    ack_t aq[$];
    rsp_t sq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t_start = 0;
    int acks_seen = 0;
    logic [3:0] rearm;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req_v, cyc);
        end
    endtask

    task automatic expect_job(input int i, input logic err);
        ack_t a;
        rsp_t r;
        a.idx = i; a.k = kv[i]; a.b = bv[i];
        r.idx = i; r.d = err ? 32'h0 : exp_data[i]; r.e = err; r.lat = err ? 66 : 12;
        aq.push_back(a);
        sq.push_back(r);
    endtask

    // Monitor: pops expectations whenever the DUT presents an ack or response.
    ack_t ma;
    rsp_t ms;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("start_ack_align", core_start, (req_ack != 4'b0));
            if (req_ack != 4'b0) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ack", req_ack, 4'b0);
                end else begin
                    ma = aq.pop_front();
                    chk("ack_onehot", req_ack, 4'b1 << ma.idx);
                    chk("core_k", core_k, ma.k);
                    chk("core_base", core_base, ma.b);
                    chk("busy_at_ack", busy, 1'b1);
                    t_start = cyc;
                end
            end
            if (rsp_valid != 4'b0) begin
                if (sq.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 4'b0);
                end else begin
                    ms = sq.pop_front();
                    chk("rsp_onehot", rsp_valid, 4'b1 << ms.idx);
                    chk("rsp_data", rsp_data, ms.d);
                    chk("rsp_err", rsp_err, ms.e);
                    chk("rsp_latency", cyc - t_start, ms.lat);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (req_ack[i]) req[i] = 1'b0;
            if (rsp_valid[i] && rearm[i]) req[i] = 1'b1;
        end
        acks_seen += $countones(req_ack);
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((aq.size() != 0 || sq.size() != 0 || busy) && n < lim);
        chk("drain_pending", aq.size() + sq.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ack"}, req_ack, 4'b0);
        chk({tag, "_rsp_valid"}, rsp_valid, 4'b0);
        chk({tag, "_rsp_data"}, rsp_data, 32'h0);
        chk({tag, "_rsp_err"}, rsp_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_core_start"}, core_start, 1'b0);
        chk({tag, "_core_k"}, core_k, 32'h0);
        chk({tag, "_core_base"}, core_base, 2'b0);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, a0;
        kv[0] = 32'h0000_0005; bv[0] = 2'd2; exp_data[0] = 32'h0000_0016;
        kv[1] = 32'h1234_5678; bv[1] = 2'd1; exp_data[1] = 32'h48D1_59E1;
        kv[2] = 32'hC000_0003; bv[2] = 2'd3; exp_data[2] = 32'h0000_000F;
        kv[3] = 32'h0000_00FF; bv[3] = 2'd0; exp_data[3] = 32'h0000_03FC;
        rst_n = 1'b0; req = 4'b0; rearm = 4'b0; hold_ready = 1'b0; core_lat = 10;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Single request from requester 0.
        expect_job(0, 1'b0);
        req = 4'b0001;
        drain(100);

        // Back-pressure: no grant while the core is not ready.
        hold_ready = 1'b1;
        req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_busy", busy, 1'b0);
            chk("bp_no_ack", req_ack, 4'b0);
        end
        expect_job(1, 1'b0);
        hold_ready = 1'b0;
        step();
        chk("bp_ack_next", req_ack, 4'b0010);
        drain(100);

        // Pointer rotation: serve 2, then 0101 grants 0 before 2.
        expect_job(2, 1'b0);
        req = 4'b0100;
        drain(100);
        expect_job(0, 1'b0);
        expect_job(2, 1'b0);
        req = 4'b0101;
        drain(200);

        // Timeout on requester 3; the late done lands in IDLE.
        core_lat = 80;
        expect_job(3, 1'b1);
        req = 4'b1000;
        drain(200);
        n = 0;
        while (!core_ready && n < 100) begin
            step();
            n++;
        end
        chk("late_done_ready", core_ready, 1'b1);
        chk("late_done_busy", busy, 1'b0);
        chk("late_done_rsp", rsp_valid, 4'b0);
        core_lat = 10;

        // Contention starting from ptr=0: grants 0,1,2,3,0.
        for (int i = 0; i < 4; i++) expect_job(i, 1'b0);
        expect_job(0, 1'b0);
        a0 = acks_seen;
        rearm = 4'b1111;
        req = 4'b1111;
        n = 0;
        while (acks_seen < a0 + 5 && n < 400) begin
            step();
            n++;
        end
        chk("contention_acks", acks_seen - a0, 5);
        req = 4'b0;
        rearm = 4'b0;
        drain(100);

        // Reset while in WAIT: no response, then service restarts with ptr=0.
        begin
            ack_t a;
            a.idx = 1; a.k = kv[1]; a.b = bv[1];
            aq.push_back(a);
        end
        req = 4'b0010;
        repeat (6) step();
        chk("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_job(0, 1'b0);
        expect_job(2, 1'b0);
        req = 4'b0101;
        drain(200);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
